// File: rtl/register_bank_sw.sv
// Banked register file with per-bank flags and a main/shadow context swap.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   Addr1, Addr2         read addresses (registered read data on Out1/Out2)
//   AddrWR, Datain, WR   write port into the active bank
//   FlagWR, FlagMask     masked flag update, mask order {C,O,S,Z}
//   Cin, Oin, Sin, Zin   new flag values
//   BankSwap             one-cycle request to toggle the active bank
//   CF, OF, SF, ZF       registered flags of the active bank
//   ActiveBank           currently active bank index
module register_bank_sw #(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned ZERO_R0   = 0,
  parameter int unsigned FWD_EN    = 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [AW-1:0] Addr1,
  input  logic [AW-1:0] Addr2,
  input  logic [AW-1:0] AddrWR,
  input  logic [DW-1:0] Datain,
  input  logic          WR,
  input  logic          FlagWR,
  input  logic [3:0]    FlagMask,
  input  logic          Cin,
  input  logic          Oin,
  input  logic          Sin,
  input  logic          Zin,
  input  logic          BankSwap,
  output logic [DW-1:0] Out1,
  output logic [DW-1:0] Out2,
  output logic          CF,
  output logic          OF,
  output logic          SF,
  output logic          ZF,
  output logic          ActiveBank
);

  localparam int unsigned NREGS  = 2 ** AW;
  localparam int unsigned NFLAGS = 4;
  // Storage always has two contexts; with a single bank the index is pinned
  // to 0 so the second context is never written and trims away.
  localparam int unsigned NSTORE = 2;

  logic [DW-1:0]     regs_q  [NSTORE][NREGS];
  logic [NFLAGS-1:0] flags_q [NSTORE];

  logic              bank_q,     bank_d;
  logic [DW-1:0]     out1_q,     out1_d;
  logic [DW-1:0]     out2_q,     out2_d;
  logic [NFLAGS-1:0] flag_out_q, flag_out_d;
  logic [NFLAGS-1:0] flags_upd;
  logic [NFLAGS-1:0] flag_in;
  logic              wr_en;

  // Next-state: reads, forwarding, masked flag update and bank toggle
  always_comb begin
    bank_d     = bank_q;
    out1_d     = regs_q[bank_q][Addr1];
    out2_d     = regs_q[bank_q][Addr2];
    flag_in    = {Cin, Oin, Sin, Zin};
    flags_upd  = flags_q[bank_q];
    wr_en      = WR;
    flag_out_d = flags_q[bank_q];

    // Writes to a hard-wired zero register vanish, forwarding included
    if ((ZERO_R0 != 0) && (AddrWR == '0)) wr_en = 1'b0;

    for (int unsigned i = 0; i < NFLAGS; i++) begin
      if (FlagWR && FlagMask[i]) flags_upd[i] = flag_in[i];
    end

    if (FWD_EN != 0) begin
      flag_out_d = flags_upd;
      if (wr_en && (AddrWR == Addr1)) out1_d = Datain;
      if (wr_en && (AddrWR == Addr2)) out2_d = Datain;
    end

    if ((ZERO_R0 != 0) && (Addr1 == '0)) out1_d = '0;
    if ((ZERO_R0 != 0) && (Addr2 == '0)) out2_d = '0;

    if ((NUM_BANKS == 2) && BankSwap) bank_d = ~bank_q;
  end

  // State: register array, flag sets, read outputs, active bank
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned b = 0; b < NSTORE; b++) begin
        flags_q[b] <= '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
          regs_q[b][r] <= '0;
        end
      end
      bank_q     <= 1'b0;
      out1_q     <= '0;
      out2_q     <= '0;
      flag_out_q <= '0;
    end else begin
      // All updates at this edge target the pre-edge bank
      if (wr_en) regs_q[bank_q][AddrWR] <= Datain;
      flags_q[bank_q] <= flags_upd;
      bank_q          <= bank_d;
      out1_q          <= out1_d;
      out2_q          <= out2_d;
      flag_out_q      <= flag_out_d;
    end
  end

  assign Out1       = out1_q;
  assign Out2       = out2_q;
  assign CF         = flag_out_q[3];
  assign OF         = flag_out_q[2];
  assign SF         = flag_out_q[1];
  assign ZF         = flag_out_q[0];
  assign ActiveBank = bank_q;

endmodule

// File: doc/register_bank_sw.md
Name: register_bank_sw

Overview:
- Parametrised successor to the 8-bit processor's register file.
- Holds NUM_BANKS x 2^AW registers of DW bits and one flag set (C, O, S, Z) per bank.
- Two registered read ports and one write port; writes are forwarded to same-cycle reads.
- Per-flag write masking, optional hard-wired zero register, and a single-cycle bank swap (main/shadow context) for interrupt entry and exit.
- Sits between the decoder/ALU and the writeback path; the control unit drives BankSwap.

Parameters:
- DW, 8, data width in bits.
- AW, 3, register address width; 2^AW registers per bank.
- NUM_BANKS, 2, number of register contexts; legal values are 1 or 2.
- ZERO_R0, 0, when 1, register 0 reads as 0 and writes to it are discarded.
- FWD_EN, 1, when 1, a same-cycle write is forwarded to the read outputs.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- Addr1  in  AW  read port 1 address.
- Addr2  in  AW  read port 2 address.
- AddrWR  in  AW  write address.
- Datain  in  DW  write data.
- WR  in  1  register write enable.
- FlagWR  in  1  flag write enable.
- FlagMask  in  4  per-flag enable, bit order {C,O,S,Z}; a flag updates only if FlagWR and its mask bit are both 1.
- Cin, Oin, Sin, Zin  in  1 each  new flag values.
- BankSwap  in  1  one-cycle request to toggle the active bank.
- Out1  out  DW  registered read data, port 1.
- Out2  out  DW  registered read data, port 2.
- CF, OF, SF, ZF  out  1 each  registered flags of the active bank.
- ActiveBank  out  1  currently active bank index.

Behaviour:
- Reset (nRST low, asynchronous): all registers in all banks = 0, all flags = 0, Out1 = Out2 = 0, CF = OF = SF = ZF = 0, ActiveBank = 0. Release takes effect at the next rising edge.
- Read latency is 1 cycle: at edge k, Out1 <= bank[ActiveBank][Addr1], Out2 likewise, with addresses and ActiveBank as sampled before the edge.
- Flag outputs at edge k are the flag set of the pre-edge ActiveBank, after that edge's masked flag write.
- Write: at the edge with WR = 1, bank[ActiveBank_pre][AddrWR] <= Datain.
- Forwarding, FWD_EN = 1:
  - If WR = 1 and AddrWR equals Addr1, Out1 gets Datain instead of the old value; same rule for Addr2/Out2.
  - Flag outputs reflect masked flag writes in the same edge.
- Forwarding, FWD_EN = 0: reads return the old contents; written data is visible one cycle later.
- ZERO_R0 = 1: a write to address 0 is dropped, including any forwarding; a read of address 0 returns 0.
- Flag update: each flag f <= FlagWR & FlagMask[f] ? fin : f. Masked-off flags hold their value.
- Bank swap (NUM_BANKS = 2): BankSwap = 1 at edge k gives ActiveBank <= ~ActiveBank.
  - Reads, the write and the flag update at edge k all use the old bank.
  - Out*/flags at edge k+1 come from the new bank.
  - Back-to-back BankSwap toggles every cycle.
- NUM_BANKS = 1: BankSwap is ignored and ActiveBank stays 0.
- Simultaneous WR + FlagWR + BankSwap: all three apply to the old bank at the same edge; none is lost.
- Reset asserted mid-operation: state clears immediately and any in-flight write is discarded.
- Widths: no arithmetic; Datain is stored verbatim, and all addresses are in range by construction.

Test Plan:
- Reset: hold nRST low 3 cycles, release, read Addr1 = 3, Addr2 = 7 -> Out1 = Out2 = 0, all flags 0, ActiveBank = 0.
- Forwarding: WR = 1, AddrWR = 5, Datain = 8'hA5, Addr1 = 5 in the same cycle -> Out1 = 8'hA5 after 1 edge. Repeat with FWD_EN = 0 -> Out1 = 0 first, then 8'hA5 the next cycle.
- Flag mask: set all flags to 1, then FlagWR = 1, FlagMask = 4'b1010, {C,O,S,Z}in = 0000 -> CF = 0, OF = 1, SF = 0, ZF = 1.
- Bank swap:
  - Write R2 = 8'h11 in bank 0.
  - Pulse BankSwap together with WR R2 = 8'h22 -> 8'h22 lands in bank 0; ActiveBank = 1 and reading R2 gives 0.
  - Swap back -> reading R2 gives 8'h22, and flags are restored.
- ZERO_R0 = 1: write 8'hFF to R0 with Addr1 = 0 -> Out1 = 0 both that cycle and the next.
- Mid-write reset: assert nRST low between edges while WR = 1 to R4 = 8'h3C -> after release, R4 reads 0 and Out1/Out2 are 0 immediately on assertion.
